// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and constants for the UART command assembler.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2
  } asm_state_t;

  localparam int CMD_BYTES        = 3;
  localparam int CMD_W            = 24;
  localparam int TIMEOUT_CLKS_DEF = 5000;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out bus; the assembler uses the slave modport.
interface uart_cmd_assembler_if;
  import uart_cmd_pkg::*;

  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             overrun;
  logic             timeout;

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, overrun, timeout
  );

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun, timeout
  );

endinterface

// File: rtl/uart_cmd_assembler_byte_timer.sv
// Inter-byte gap counter; expired flags the cycle whose edge discards a partial command.
module byte_timer #(
  parameter int TIMEOUT_CLKS = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] count_reg;

  assign expired = run && !clr && (count_reg == LAST);

  // Restarting at LAST keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || !run || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles three received bytes (MSB first) into a 24-bit command with overrun and gap timeout.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_cmd_assembler_if.slave bus
);

  asm_state_t       state_reg;
  logic [7:0]       byte0_reg;
  logic [7:0]       byte1_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic             cmd_rdy_reg;
  logic             overrun_reg;
  logic             timeout_reg;
  logic             expired;
  logic             last_byte;

  assign last_byte = bus.rx_rdy && (state_reg == BYTE2);

  byte_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.rx_rdy),
    .run     (state_reg != BYTE0),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BYTE0;
      byte0_reg   <= '0;
      byte1_reg   <= '0;
      cmd_reg     <= '0;
      cmd_rdy_reg <= 1'b0;
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= expired;

      if (bus.rx_rdy) begin
        case (state_reg)
          BYTE0: begin
            byte0_reg <= bus.rx_data;
            state_reg <= BYTE1;
          end
          BYTE1: begin
            byte1_reg <= bus.rx_data;
            state_reg <= BYTE2;
          end
          BYTE2: begin
            cmd_reg   <= {byte0_reg, byte1_reg, bus.rx_data};
            state_reg <= BYTE0;
          end
          default: state_reg <= BYTE0;
        endcase
      end else if (expired) begin
        state_reg <= BYTE0;
      end

      // A completing byte outranks the consumer's acknowledge.
      if (last_byte) begin
        cmd_rdy_reg <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
      end

      if (last_byte && cmd_rdy_reg && !bus.clr_cmd_rdy) begin
        overrun_reg <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.cmd        = cmd_reg;
  assign bus.cmd_rdy    = cmd_rdy_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.timeout    = timeout_reg;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench: one instance at the default timeout, one with a 10-cycle timeout.
module tb_uart_cmd_assembler;

  logic clk = 1'b0;
  logic rst_n_l;
  logic rst_n_s;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_cmd_assembler_if bus_l();
  uart_cmd_assembler_if bus_s();

  uart_cmd_assembler dut_l (
    .clk   (clk),
    .rst_n (rst_n_l),
    .bus   (bus_l)
  );

  uart_cmd_assembler #(.TIMEOUT_CLKS(10)) dut_s (
    .clk   (clk),
    .rst_n (rst_n_s),
    .bus   (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; presents one byte for one cycle and returns on the next negedge.
  task automatic send_byte(input bit sel, input logic [7:0] data, input bit with_clr);
    if (sel) begin
      bus_s.rx_data = data; bus_s.rx_rdy = 1'b1; bus_s.clr_cmd_rdy = with_clr;
      #1 check("clr_rx_rdy_s", {31'd0, bus_s.clr_rx_rdy}, 32'd1);
    end else begin
      bus_l.rx_data = data; bus_l.rx_rdy = 1'b1; bus_l.clr_cmd_rdy = with_clr;
      #1 check("clr_rx_rdy_l", {31'd0, bus_l.clr_rx_rdy}, 32'd1);
    end
    @(negedge clk);
    bus_s.rx_rdy = 1'b0; bus_l.rx_rdy = 1'b0;
    bus_s.clr_cmd_rdy = 1'b0; bus_l.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) bus_s.clr_cmd_rdy = 1'b1;
    else     bus_l.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus_s.clr_cmd_rdy = 1'b0; bus_l.clr_cmd_rdy = 1'b0;
  endtask

  // Idles the short-timeout instance, counting timeout pulses and the cycle of the first.
  task automatic idle_watch(input int n, output int pulses, output int first_at);
    pulses = 0; first_at = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus_s.timeout) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int first_at;

    rst_n_l = 1'b0; rst_n_s = 1'b0;
    bus_l.rx_data = '0; bus_l.rx_rdy = 1'b0; bus_l.clr_cmd_rdy = 1'b0;
    bus_s.rx_data = '0; bus_s.rx_rdy = 1'b0; bus_s.clr_cmd_rdy = 1'b0;
    #2;
    check("rst_cmd_l", {8'd0, bus_l.cmd}, 32'h0);
    check("rst_flags_l", {28'd0, bus_l.cmd_rdy, bus_l.overrun, bus_l.timeout, bus_l.clr_rx_rdy}, 32'h0);
    check("rst_flags_s", {28'd0, bus_s.cmd_rdy, bus_s.overrun, bus_s.timeout, bus_s.clr_rx_rdy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n_l = 1'b1; rst_n_s = 1'b1;
    @(negedge clk);

    // Slow three-byte command on the default-timeout instance.
    send_byte(1'b0, 8'hA5, 1'b0);
    repeat (99) @(negedge clk);
    send_byte(1'b0, 8'h12, 1'b0);
    repeat (99) @(negedge clk);
    check("pre_rdy", {31'd0, bus_l.cmd_rdy}, 32'd0);
    send_byte(1'b0, 8'h3C, 1'b0);
    check("cmd_a5123c", {8'd0, bus_l.cmd}, 32'hA5123C);
    check("rdy_after_3", {31'd0, bus_l.cmd_rdy}, 32'd1);
    check("ovr_after_3", {31'd0, bus_l.overrun}, 32'd0);
    check("clr_rx_idle", {31'd0, bus_l.clr_rx_rdy}, 32'd0);

    // Acknowledge, then acknowledge coincident with a completing byte.
    pulse_clr(1'b0);
    check("rdy_cleared", {31'd0, bus_l.cmd_rdy}, 32'd0);
    check("cmd_kept", {8'd0, bus_l.cmd}, 32'hA5123C);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    send_byte(1'b0, 8'h03, 1'b0);
    check("cmd_010203_l", {8'd0, bus_l.cmd}, 32'h010203);
    send_byte(1'b0, 8'h04, 1'b0);
    send_byte(1'b0, 8'h05, 1'b0);
    send_byte(1'b0, 8'h06, 1'b1);
    check("set_wins_rdy", {31'd0, bus_l.cmd_rdy}, 32'd1);
    check("set_wins_cmd", {8'd0, bus_l.cmd}, 32'h040506);
    check("no_ovr_w_clr", {31'd0, bus_l.overrun}, 32'd0);

    // Overrun: two commands with no acknowledge in between.
    pulse_clr(1'b0);
    send_byte(1'b0, 8'h10, 1'b0);
    send_byte(1'b0, 8'h20, 1'b0);
    send_byte(1'b0, 8'h30, 1'b0);
    check("ovr_first", {31'd0, bus_l.overrun}, 32'd0);
    send_byte(1'b0, 8'h40, 1'b0);
    send_byte(1'b0, 8'h50, 1'b0);
    send_byte(1'b0, 8'h60, 1'b0);
    check("ovr_cmd", {8'd0, bus_l.cmd}, 32'h405060);
    check("ovr_set", {31'd0, bus_l.overrun}, 32'd1);
    check("ovr_rdy", {31'd0, bus_l.cmd_rdy}, 32'd1);
    pulse_clr(1'b0);
    check("ovr_clr", {31'd0, bus_l.overrun}, 32'd0);
    check("ovr_clr_rdy", {31'd0, bus_l.cmd_rdy}, 32'd0);

    // Timeout after a lone byte, then a clean command.
    send_byte(1'b1, 8'h11, 1'b0);
    idle_watch(14, pulses, first_at);
    check("to_pulses", pulses, 32'd1);
    check("to_cycle", first_at, 32'd10);
    check("to_keeps_rdy", {31'd0, bus_s.cmd_rdy}, 32'd0);
    send_byte(1'b1, 8'h22, 1'b0);
    send_byte(1'b1, 8'h33, 1'b0);
    send_byte(1'b1, 8'h44, 1'b0);
    check("cmd_223344", {8'd0, bus_s.cmd}, 32'h223344);
    check("rdy_223344", {31'd0, bus_s.cmd_rdy}, 32'd1);

    // A byte landing on the timeout cycle is kept.
    pulse_clr(1'b1);
    send_byte(1'b1, 8'hAA, 1'b0);
    idle_watch(9, pulses, first_at);
    send_byte(1'b1, 8'hBB, 1'b0);
    check("edge_no_to", {31'd0, bus_s.timeout}, 32'd0);
    check("edge_pulses", pulses, 32'd0);
    send_byte(1'b1, 8'hCC, 1'b0);
    check("cmd_aabbcc", {8'd0, bus_s.cmd}, 32'hAABBCC);
    check("ovr_s", {31'd0, bus_s.overrun}, 32'd0);

    // Mid-command reset drops partial bytes.
    send_byte(1'b1, 8'h77, 1'b0);
    send_byte(1'b1, 8'h88, 1'b0);
    rst_n_s = 1'b0;
    bus_s.rx_data = 8'h99; bus_s.rx_rdy = 1'b1;
    #1;
    check("mrst_cmd", {8'd0, bus_s.cmd}, 32'h0);
    check("mrst_flags", {29'd0, bus_s.cmd_rdy, bus_s.overrun, bus_s.timeout}, 32'h0);
    check("mrst_clr_rx", {31'd0, bus_s.clr_rx_rdy}, 32'd1);
    @(negedge clk);
    rst_n_s = 1'b1; bus_s.rx_rdy = 1'b0;
    @(negedge clk);
    send_byte(1'b1, 8'h01, 1'b0);
    send_byte(1'b1, 8'h02, 1'b0);
    send_byte(1'b1, 8'h03, 1'b0);
    check("cmd_010203_s", {8'd0, bus_s.cmd}, 32'h010203);
    check("rdy_010203_s", {31'd0, bus_s.cmd_rdy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_assembler.md
UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 5000, sets the maximum number of clk cycles allowed between bytes of one command before the partial command is discarded; it SHALL be at least 2.
REQ-002 Port clk, input, 1 bit, is the system clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit, is the reset; it SHALL be asynchronous and active-low.
REQ-004 Port rx_data, input, 8 bits, is the received byte from the UART receiver.
REQ-005 Port rx_rdy, input, 1 bit, indicates a received byte is valid on rx_data.
REQ-006 Port clr_rx_rdy, output, 1 bit, acknowledges and clears the receiver's ready flag.
REQ-007 Port cmd, output, 24 bits, is the assembled command.
REQ-008 Port cmd_rdy, output, 1 bit, indicates cmd holds a complete, unconsumed command.
REQ-009 Port clr_cmd_rdy, input, 1 bit, is the consumer's acknowledge of cmd.
REQ-010 Port overrun, output, 1 bit, is a sticky flag: a new command overwrote an unconsumed one.
REQ-011 Port timeout, output, 1 bit, is a one-cycle pulse indicating a partial command was discarded.

Function
REQ-012 State machine states SHALL be BYTE0, BYTE1 and BYTE2, where each state means that many bytes of the current command are already held.
REQ-013 A byte SHALL be accepted in every cycle in which rx_rdy=1, in any state.
REQ-014 clr_rx_rdy SHALL be combinational and equal to rx_rdy, so the acknowledge is asserted in the same cycle the byte is accepted.
REQ-015 Bytes SHALL arrive most-significant first: byte 0 goes to cmd[23:16], byte 1 to cmd[15:8], byte 2 to cmd[7:0].
REQ-016 Transitions on byte acceptance SHALL be BYTE0->BYTE1, BYTE1->BYTE2 and BYTE2->BYTE0.
REQ-017 Byte 0 and byte 1 SHALL be held in internal registers; cmd SHALL update only on acceptance of byte 2, loading all 24 bits at once.
REQ-018 cmd_rdy SHALL go to 1 on the clk edge that accepts byte 2, making it visible the cycle after rx_rdy; this is latency 1.
REQ-019 cmd_rdy SHALL go to 0 on the clk edge where clr_cmd_rdy=1 and no byte 2 is accepted; when both occur in the same cycle, set SHALL win.
REQ-020 When byte 2 is accepted while cmd_rdy=1 and clr_cmd_rdy=0, cmd SHALL be overwritten, cmd_rdy SHALL stay 1 and overrun SHALL be set.
REQ-021 overrun SHALL be cleared by clr_cmd_rdy=1, except that set SHALL win when a set condition occurs in the same cycle.
REQ-022 The inter-byte counter SHALL be held at 0 in BYTE0, cleared on every accepted byte, and incremented by 1 each cycle in BYTE1 or BYTE2 without a byte.
REQ-023 The inter-byte counter width SHALL be $clog2(TIMEOUT_CLKS+1) bits, and it SHALL never wrap.
REQ-024 When the counter equals TIMEOUT_CLKS-1 and no byte is accepted, the block SHALL on the next edge enter BYTE0, clear the counter, and assert timeout for exactly one cycle.
REQ-025 During a timeout, cmd, cmd_rdy and overrun SHALL be unchanged.
REQ-026 A byte accepted in the cycle where timeout would fire SHALL be taken as a normal byte, and no timeout SHALL occur.
REQ-027 After a timeout, the next accepted byte SHALL be treated as byte 0.
REQ-028 clr_cmd_rdy SHALL have no effect on assembly state or on the inter-byte counter.

Reset
REQ-029 On rst_n=0, state SHALL be BYTE0 and the counter SHALL be 0.
REQ-030 On rst_n=0, cmd, the byte registers, cmd_rdy, overrun and timeout SHALL be 0.
REQ-031 On rst_n=0, clr_rx_rdy SHALL follow rx_rdy.
REQ-032 A reset in mid-command SHALL discard partial bytes, so the first byte accepted after reset is byte 0.

Structure
REQ-033 A shared package uart_cmd_pkg SHALL hold the state enum, CMD_BYTES=3, CMD_W=24 and the default TIMEOUT_CLKS.
REQ-034 The inter-byte counter and its timeout compare SHALL be a separate sub-module, byte_timer, with inputs clr and run, output expired, and parameter TIMEOUT_CLKS.

Verification
REQ-035 Bytes 0xA5, 0x12, 0x3C, each as a 1-cycle rx_rdy 100 cycles apart -> clr_rx_rdy pulses with each byte, cmd=0xA5123C and cmd_rdy=1 one cycle after the 3rd rx_rdy, overrun=0.
REQ-036 Hold cmd_rdy=1 and pulse clr_cmd_rdy -> cmd_rdy=0 next cycle and cmd unchanged; repeat with clr_cmd_rdy coincident with a 3rd byte -> cmd_rdy remains 1.
REQ-037 With TIMEOUT_CLKS=10, send byte 0x11 then idle -> timeout pulses once 10 cycles later; then send 0x22, 0x33, 0x44 -> cmd=0x223344.
REQ-038 With TIMEOUT_CLKS=10, send a 2nd byte exactly on the timeout cycle -> no timeout pulse; a 3rd byte then completes the command.
REQ-039 Send two full commands without clr_cmd_rdy -> cmd equals the 2nd command and overrun=1; pulse clr_cmd_rdy -> overrun=0 and cmd_rdy=0.
REQ-040 Send 2 bytes, assert rst_n=0 for 1 cycle, then send 0x01, 0x02, 0x03 -> all outputs read 0 during reset and cmd=0x010203 afterwards.
